// File: rtl/fmc_pkg.sv
// Shared types and constants for the frame memory controller SRAM port.
//   rd_state_e        : read-frame sequencer states
//   arb_prio_e        : round-robin owner of the next contended SRAM slot
//   FMC_H_ACTIVE/V    : default frame geometry
//   FMC_RD_FIFO_DEPTH : read return FIFO depth, also the read credit limit
package fmc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } rd_state_e;

  typedef enum logic {
    PrioWr,
    PrioRd
  } arb_prio_e;

  localparam int unsigned FMC_H_ACTIVE      = 1080;
  localparam int unsigned FMC_V_ACTIVE      = 2400;
  localparam int unsigned FMC_RD_FIFO_DEPTH = 4;

endpackage

// File: rtl/fmc_sram_port_if.sv
// Bundle of the pixel write stream, pixel read stream and SRAM command/data signals.
//   slave  : the fmc_sram_port view (consumes write pixels, drives the SRAM)
//   master : the surrounding system view (pixel source/sink and SRAM macro)
interface fmc_sram_port_if #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH = $clog2(fmc_pkg::FMC_H_ACTIVE * fmc_pkg::FMC_V_ACTIVE)
);

  logic                  WR_VALID;
  logic                  WR_READY;
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  WR_SOF;
  logic                  WR_FRAME_DONE;
  logic                  RD_START;
  logic                  RD_BUSY;
  logic                  RD_VALID;
  logic                  RD_READY;
  logic [DATA_WIDTH-1:0] RD_DATA;
  logic                  RD_SOF;
  logic                  RD_EOF;
  logic                  CSN;
  logic                  WEN;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [DATA_WIDTH-1:0] DIN;
  logic [DATA_WIDTH-1:0] DOUT;

  modport slave (
    input  WR_VALID, WR_DATA, WR_SOF, RD_START, RD_READY, DOUT,
    output WR_READY, WR_FRAME_DONE, RD_BUSY, RD_VALID, RD_DATA, RD_SOF, RD_EOF,
    output CSN, WEN, ADDR, DIN
  );

  modport master (
    output WR_VALID, WR_DATA, WR_SOF, RD_START, RD_READY, DOUT,
    input  WR_READY, WR_FRAME_DONE, RD_BUSY, RD_VALID, RD_DATA, RD_SOF, RD_EOF,
    input  CSN, WEN, ADDR, DIN
  );

endinterface

// File: rtl/SPSRAM.sv
// Single-port synchronous SRAM model: one access per cycle, registered read data.
//   CSN/WEN : active-low select / write enable
//   ADDR    : word address, DIN write data, DOUT read data valid the cycle after the command
module SPSRAM #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  CSN,
  input  logic                  WEN,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [DATA_WIDTH-1:0] DIN,
  output logic [DATA_WIDTH-1:0] DOUT
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge CLK) begin
    if (!CSN) begin
      if (!WEN) mem[ADDR] <= DIN;
      else      DOUT      <= mem[ADDR];
    end
  end

endmodule

// File: rtl/fmc_sync_fifo.sv
// Synchronous FIFO with asynchronous active-low reset.
//   CLK, RSTN : clock, async active-low reset
//   push/wdata: write side (push while full is dropped)
//   pop/rdata : read side, rdata shows the head entry (pop while empty is ignored)
//   empty     : no entries stored
//   count     : number of entries stored
module fmc_sync_fifo #(
  parameter  int unsigned Width = 26,
  parameter  int unsigned Depth = 4,
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt_q == '0);
  assign do_push = push && (cnt_q != CntW'(Depth));
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q];
  assign count   = cnt_q;

  // Storage needs no reset: entries are only visible through the reset pointers.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/fmc_sram_port.sv
// Single-port SRAM initiator: writes an incoming pixel stream into the frame buffer and, on
// RD_START, streams a whole frame back out. Write and read share the SRAM port round-robin;
// a 4-entry return FIFO absorbs the 2-cycle SRAM read loop under downstream backpressure.
//   CLK, RSTN : clock, async active-low reset
//   bus       : pixel write stream, pixel read stream, SRAM command/data (slave modport)
module fmc_sram_port
  import fmc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned H_ACTIVE   = FMC_H_ACTIVE,
  parameter int unsigned V_ACTIVE   = FMC_V_ACTIVE,
  parameter int unsigned ADDR_DEPTH = H_ACTIVE * V_ACTIVE,
  parameter int unsigned ADDR_WIDTH = $clog2(ADDR_DEPTH)
) (
  input logic           CLK,
  input logic           RSTN,
  fmc_sram_port_if.slave bus
);

  localparam int unsigned CntW = $clog2(FMC_RD_FIFO_DEPTH + 1);
  localparam int unsigned OutW = CntW + 1;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(ADDR_DEPTH - 1);

  rd_state_e             state_q, state_d;
  arb_prio_e             prio_q, prio_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  csn_q, csn_d, wen_q, wen_d, done_q, done_d;
  // Read pipeline: stage 0 = command on the SRAM pins, stage 1 = DOUT valid.
  logic [1:0]            sr_vld_q, sr_vld_d, sr_sof_q, sr_sof_d, sr_eof_q, sr_eof_d;

  logic                  fifo_empty, fifo_pop;
  logic [CntW-1:0]       fifo_count;
  logic [DATA_WIDTH+1:0] fifo_rdata;
  logic [OutW-1:0]       outstanding;
  logic                  rd_want, wr_grant, rd_issue, rd_last;
  logic [ADDR_WIDTH-1:0] wr_gnt_addr;

  // Credits cover everything already committed: queued in the FIFO or still in the pipe.
  assign outstanding = OutW'(fifo_count) + OutW'(sr_vld_q[0]) + OutW'(sr_vld_q[1]);
  assign rd_want     = (state_q == StIssue) && (outstanding < OutW'(FMC_RD_FIFO_DEPTH));
  assign bus.WR_READY = !rd_want || (prio_q == PrioWr);
  assign wr_grant    = bus.WR_VALID && bus.WR_READY;
  assign rd_issue    = rd_want && !wr_grant;
  assign rd_last     = (rd_addr_q == LastAddr);
  assign wr_gnt_addr = bus.WR_SOF ? '0 : wr_addr_q;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    csn_d     = 1'b1;
    wen_d     = 1'b1;
    addr_d    = addr_q;
    din_d     = din_q;
    done_d    = 1'b0;
    sr_vld_d  = {sr_vld_q[0], 1'b0};
    sr_sof_d  = {sr_sof_q[0], 1'b0};
    sr_eof_d  = {sr_eof_q[0], 1'b0};

    if (wr_grant) begin
      csn_d     = 1'b0;
      wen_d     = 1'b0;
      addr_d    = wr_gnt_addr;
      din_d     = bus.WR_DATA;
      wr_addr_d = (wr_gnt_addr == LastAddr) ? '0 : wr_gnt_addr + 1'b1;
      done_d    = (wr_gnt_addr == LastAddr);
      prio_d    = PrioRd;
    end else if (rd_issue) begin
      csn_d       = 1'b0;
      addr_d      = rd_addr_q;
      rd_addr_d   = rd_last ? '0 : rd_addr_q + 1'b1;
      prio_d      = PrioWr;
      sr_vld_d[0] = 1'b1;
      sr_sof_d[0] = (rd_addr_q == '0);
      sr_eof_d[0] = rd_last;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.RD_START) begin
          state_d   = StIssue;
          rd_addr_d = '0;
        end
      end
      StIssue: begin
        if (rd_issue && rd_last) state_d = StDrain;
      end
      StDrain: begin
        if (fifo_empty && (sr_vld_q == 2'b00)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= StIdle;
      prio_q    <= PrioWr;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      csn_q     <= 1'b1;
      wen_q     <= 1'b1;
      addr_q    <= '0;
      din_q     <= '0;
      done_q    <= 1'b0;
      sr_vld_q  <= '0;
      sr_sof_q  <= '0;
      sr_eof_q  <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      csn_q     <= csn_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      done_q    <= done_d;
      sr_vld_q  <= sr_vld_d;
      sr_sof_q  <= sr_sof_d;
      sr_eof_q  <= sr_eof_d;
    end
  end

  assign fifo_pop = !fifo_empty && bus.RD_READY;

  fmc_sync_fifo #(
    .Width (DATA_WIDTH + 2),
    .Depth (FMC_RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .push  (sr_vld_q[1]),
    .wdata ({sr_eof_q[1], sr_sof_q[1], bus.DOUT}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {bus.RD_EOF, bus.RD_SOF, bus.RD_DATA} = fifo_rdata;
  assign bus.RD_VALID      = !fifo_empty;
  assign bus.RD_BUSY       = (state_q != StIdle);
  assign bus.WR_FRAME_DONE = done_q;
  assign bus.CSN           = csn_q;
  assign bus.WEN           = wen_q;
  assign bus.ADDR          = addr_q;
  assign bus.DIN           = din_q;

endmodule
